// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: field positions, widths, opcode values and op classes.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package decode_stage_pkg;

    localparam int PC_WIDTH  = 16;
    localparam int IR_WIDTH  = 32;
    localparam int REG_WIDTH = 16;
    localparam int NUM_REGS  = 16;
    localparam int REG_IDX_W = 4;
    localparam int OPC_WIDTH = 8;
    localparam int BUSY_W    = 2;

    // Instruction field LSB positions
    localparam int OPC_LSB  = 24;
    localparam int DEST_LSB = 20;
    localparam int SRC1_LSB = 16;
    localparam int SRC2_LSB = 8;
    localparam int IMM_LSB  = 0;

    localparam logic [BUSY_W-1:0] BUSY_MAX = '1;

    // Opcode encodings
    localparam logic [OPC_WIDTH-1:0] OP_NOP  = 8'hFF;
    localparam logic [OPC_WIDTH-1:0] OP_ADD  = 8'h01;
    localparam logic [OPC_WIDTH-1:0] OP_SUB  = 8'h02;
    localparam logic [OPC_WIDTH-1:0] OP_ADDI = 8'h03;
    localparam logic [OPC_WIDTH-1:0] OP_MOVI = 8'h04;
    localparam logic [OPC_WIDTH-1:0] OP_BRZ  = 8'h10;
    localparam logic [OPC_WIDTH-1:0] OP_JMP  = 8'h11;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_BRANCH = 2'd1,
        CLS_WRITE  = 2'd2
    } op_class_e;

    typedef struct packed {
        op_class_e cls;
        logic      use_src1;
        logic      use_src2;
    } op_info_t;

    // Decode/execute pipeline latch contents
    typedef struct packed {
        logic [PC_WIDTH-1:0]  pc;
        logic [OPC_WIDTH-1:0] opc;
        logic [REG_IDX_W-1:0] dest;
        logic [REG_WIDTH-1:0] src1;
        logic [REG_WIDTH-1:0] src2;
        logic [REG_WIDTH-1:0] imm;
        logic                 vld;
    } de_latch_t;

    localparam de_latch_t DE_RESET = '{pc: '0, opc: OP_NOP, dest: '0,
                                       src1: '0, src2: '0, imm: '0, vld: 1'b0};

    // Class and source usage of each opcode; unknown opcodes read and write nothing
    function automatic op_info_t decode_op(input logic [OPC_WIDTH-1:0] opc);
        op_info_t info;
        info = '{cls: CLS_NONE, use_src1: 1'b0, use_src2: 1'b0};
        case (opc)
            OP_ADD, OP_SUB: info = '{cls: CLS_WRITE,  use_src1: 1'b1, use_src2: 1'b1};
            OP_ADDI:        info = '{cls: CLS_WRITE,  use_src1: 1'b1, use_src2: 1'b0};
            OP_MOVI:        info = '{cls: CLS_WRITE,  use_src1: 1'b0, use_src2: 1'b0};
            OP_BRZ:         info = '{cls: CLS_BRANCH, use_src1: 1'b1, use_src2: 1'b0};
            OP_JMP:         info = '{cls: CLS_BRANCH, use_src1: 1'b0, use_src2: 1'b0};
            default:        info = '{cls: CLS_NONE,   use_src1: 1'b0, use_src2: 1'b0};
        endcase
        return info;
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// 16x16 GPR file (rising-edge write, combinational read) plus 2-bit busy counters per GPR.
// Latency: reads are combinational; busy counters update on the falling edge.
// Backpressure: none; the caller only raises inc_vld when an issue is allowed.
module decode_regfile
    import decode_stage_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [REG_IDX_W-1:0]                 rd1_idx,
    input  logic [REG_IDX_W-1:0]                 rd2_idx,
    output logic [REG_WIDTH-1:0]                 rd1_dat,
    output logic [REG_WIDTH-1:0]                 rd2_dat,
    input  logic                                 wb_vld,
    input  logic [REG_IDX_W-1:0]                 wb_dest,
    input  logic [REG_WIDTH-1:0]                 wb_dat,
    input  logic                                 inc_vld,
    input  logic [REG_IDX_W-1:0]                 inc_idx,
    output logic [NUM_REGS-1:0][BUSY_W-1:0]      busy_eff
);

    logic [NUM_REGS-1:0][REG_WIDTH-1:0] gpr_q, gpr_d;
    logic [NUM_REGS-1:0][BUSY_W-1:0]    busy_q, busy_d;

    // Writeback updates the addressed register
    always_comb begin
        gpr_d = gpr_q;
        if (wb_vld) gpr_d[wb_dest] = wb_dat;
    end

    // GPR storage written on the rising edge so the falling-edge latch sees new data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) gpr_q <= '0;
        else     gpr_q <= gpr_d;
    end

    assign rd1_dat = gpr_q[rd1_idx];
    assign rd2_dat = gpr_q[rd2_idx];

    // Busy counts with this cycle's writeback already retired (never below zero)
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_eff[i] = busy_q[i];
            if (wb_vld && wb_dest == REG_IDX_W'(i) && busy_q[i] != '0)
                busy_eff[i] = busy_q[i] - 2'd1;
        end
    end

    // Issue bumps the destination count; saturated counters are never bumped
    always_comb begin
        busy_d = busy_eff;
        if (inc_vld && busy_eff[inc_idx] != BUSY_MAX)
            busy_d[inc_idx] = busy_eff[inc_idx] + 2'd1;
    end

    // Busy counters share the pipeline's falling-edge timing
    always_ff @(negedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field extraction, operand read, RAW/WAW scoreboard stall, branch stall, D/E latch.
// Latency: one falling edge from I_IR to O_Opcode.
// Backpressure: dep/branch stalls go to fetch; I_GPUStallSignal freezes the latch; I_LOCK=0 injects bubbles.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic                  I_CLOCK,
    input  logic                  I_RESET,
    input  logic                  I_LOCK,
    input  logic [PC_WIDTH-1:0]   I_PC,
    input  logic [IR_WIDTH-1:0]   I_IR,
    input  logic                  I_FE_Valid,
    input  logic                  I_WB_Valid,
    input  logic [REG_IDX_W-1:0]  I_WB_Dest,
    input  logic [REG_WIDTH-1:0]  I_WB_Data,
    input  logic                  I_BranchAddrSelect,
    input  logic                  I_GPUStallSignal,
    output logic                  O_LOCK,
    output logic                  O_BranchStallSignal,
    output logic                  O_DepStallSignal,
    output logic [PC_WIDTH-1:0]   O_PC,
    output logic [OPC_WIDTH-1:0]  O_Opcode,
    output logic [REG_IDX_W-1:0]  O_DestRegIdx,
    output logic [REG_WIDTH-1:0]  O_Src1Value,
    output logic [REG_WIDTH-1:0]  O_Src2Value,
    output logic [REG_WIDTH-1:0]  O_Imm,
    output logic                  O_DE_Valid
);

    logic [OPC_WIDTH-1:0]            opcode;
    logic [REG_IDX_W-1:0]            dest, src1, src2;
    logic [REG_WIDTH-1:0]            imm, rd1_dat, rd2_dat;
    logic [NUM_REGS-1:0][BUSY_W-1:0] busy_eff;
    op_info_t                        info;
    logic                            bubble, dep_stall, issue;
    de_latch_t                       lat_q, lat_d;
    logic                            br_pend_q, br_pend_d;
    logic                            lock_q, lock_d;

    assign opcode = I_IR[OPC_LSB  +: OPC_WIDTH];
    assign dest   = I_IR[DEST_LSB +: REG_IDX_W];
    assign src1   = I_IR[SRC1_LSB +: REG_IDX_W];
    assign src2   = I_IR[SRC2_LSB +: REG_IDX_W];
    assign imm    = I_IR[IMM_LSB  +: REG_WIDTH];
    assign bubble = !I_FE_Valid || (opcode == OP_NOP);

    // Classify the fetched opcode
    always_comb info = decode_op(opcode);

    // Stall on a busy source, or on a destination whose counter is saturated
    always_comb begin
        dep_stall = 1'b0;
        if (!bubble) begin
            if (info.use_src1 && busy_eff[src1] != '0)         dep_stall = 1'b1;
            if (info.use_src2 && busy_eff[src2] != '0)         dep_stall = 1'b1;
            if (info.cls == CLS_WRITE && busy_eff[dest] == BUSY_MAX) dep_stall = 1'b1;
        end
    end

    // Wrong-path instructions behind a pending branch never issue
    assign issue = I_LOCK && !I_GPUStallSignal && !dep_stall && !bubble && !br_pend_q;

    decode_regfile u_regfile (
        .clk      (I_CLOCK),
        .rst      (I_RESET),
        .rd1_idx  (src1),
        .rd2_idx  (src2),
        .rd1_dat  (rd1_dat),
        .rd2_dat  (rd2_dat),
        .wb_vld   (I_WB_Valid),
        .wb_dest  (I_WB_Dest),
        .wb_dat   (I_WB_Data),
        .inc_vld  (issue && info.cls == CLS_WRITE),
        .inc_idx  (dest),
        .busy_eff (busy_eff)
    );

    // Next D/E latch contents and branch-pending flag
    always_comb begin
        lat_d     = lat_q;
        br_pend_d = br_pend_q && !I_BranchAddrSelect;
        lock_d    = I_LOCK;
        if (!I_LOCK) begin
            lat_d.opc = OP_NOP;
            lat_d.vld = 1'b0;
            br_pend_d = 1'b0;
        end else if (I_GPUStallSignal) begin
            lat_d = lat_q;
        end else if (dep_stall) begin
            lat_d.opc = OP_NOP;
            lat_d.vld = 1'b0;
        end else begin
            lat_d.pc   = I_PC;
            lat_d.opc  = bubble ? OP_NOP : opcode;
            lat_d.dest = dest;
            lat_d.src1 = (!bubble && info.use_src1) ? rd1_dat : '0;
            lat_d.src2 = (!bubble && info.use_src2) ? rd2_dat : '0;
            lat_d.imm  = imm;
            lat_d.vld  = I_FE_Valid && !bubble && !br_pend_q;
            if (issue && info.cls == CLS_BRANCH) br_pend_d = 1'b1;
        end
    end

    // Pipeline latches update on the falling edge
    always_ff @(negedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            lat_q     <= DE_RESET;
            br_pend_q <= 1'b0;
            lock_q    <= 1'b0;
        end else begin
            lat_q     <= lat_d;
            br_pend_q <= br_pend_d;
            lock_q    <= lock_d;
        end
    end

    assign O_LOCK              = lock_q;
    assign O_BranchStallSignal = br_pend_q;
    assign O_DepStallSignal    = dep_stall;
    assign O_PC                = lat_q.pc;
    assign O_Opcode            = lat_q.opc;
    assign O_DestRegIdx        = lat_q.dest;
    assign O_Src1Value         = lat_q.src1;
    assign O_Src2Value         = lat_q.src2;
    assign O_Imm               = lat_q.imm;
    assign O_DE_Valid          = lat_q.vld;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus pushes expected issues, a monitor pops them.
// Latency: inputs change 2 time units after each falling edge, outputs sampled 1 unit after it.
// Backpressure: stall signals are checked directly by the stimulus process.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic        I_CLOCK = 1'b0;
    logic        I_RESET, I_LOCK, I_FE_Valid, I_WB_Valid, I_BranchAddrSelect, I_GPUStallSignal;
    logic [15:0] I_PC, I_WB_Data;
    logic [31:0] I_IR;
    logic [3:0]  I_WB_Dest;
    logic        O_LOCK, O_BranchStallSignal, O_DepStallSignal, O_DE_Valid;
    logic [15:0] O_PC, O_Src1Value, O_Src2Value, O_Imm;
    logic [7:0]  O_Opcode;
    logic [3:0]  O_DestRegIdx;

    decode_stage dut (
        .I_CLOCK(I_CLOCK), .I_RESET(I_RESET), .I_LOCK(I_LOCK), .I_PC(I_PC), .I_IR(I_IR),
        .I_FE_Valid(I_FE_Valid), .I_WB_Valid(I_WB_Valid), .I_WB_Dest(I_WB_Dest),
        .I_WB_Data(I_WB_Data), .I_BranchAddrSelect(I_BranchAddrSelect),
        .I_GPUStallSignal(I_GPUStallSignal), .O_LOCK(O_LOCK),
        .O_BranchStallSignal(O_BranchStallSignal), .O_DepStallSignal(O_DepStallSignal),
        .O_PC(O_PC), .O_Opcode(O_Opcode), .O_DestRegIdx(O_DestRegIdx),
        .O_Src1Value(O_Src1Value), .O_Src2Value(O_Src2Value), .O_Imm(O_Imm),
        .O_DE_Valid(O_DE_Valid)
    );

    always #5 I_CLOCK = ~I_CLOCK;

    typedef struct packed {
        logic [15:0] pc;
        logic [7:0]  opc;
        logic [3:0]  dest;
        logic [15:0] s1;
        logic [15:0] s2;
        logic [15:0] imm;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [31:0] ir_rrr(input logic [7:0] op, input logic [3:0] d,
                                           input logic [3:0] s1, input logic [3:0] s2);
        return {op, d, s1, 4'h0, s2, 8'h00};
    endfunction

    function automatic logic [31:0] ir_ri(input logic [7:0] op, input logic [3:0] d,
                                          input logic [3:0] s1, input logic [15:0] imm);
        return {op, d, s1, imm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge I_CLOCK);
        #2;
    endtask

    task automatic drive(input logic fe, input logic [31:0] ir, input logic [15:0] pc);
        I_FE_Valid = fe;
        I_IR       = ir;
        I_PC       = pc;
    endtask

    task automatic idle();
        drive(1'b0, 32'hFF00_0000, 16'h0000);
    endtask

    task automatic wb(input logic v, input logic [3:0] d, input logic [15:0] dat);
        I_WB_Valid = v;
        I_WB_Dest  = d;
        I_WB_Data  = dat;
    endtask

    task automatic push(input logic [15:0] pc, input logic [7:0] opc, input logic [3:0] d,
                        input logic [15:0] s1, input logic [15:0] s2, input logic [15:0] imm);
        exp_t e;
        e = {pc, opc, d, s1, s2, imm};
        exp_q.push_back(e);
    endtask

    task automatic chk_dep(input logic req, input string name);
        #1;
        check(name, 32'(O_DepStallSignal), 32'(req));
    endtask

    task automatic chk_reset_vals(input string tag);
        check({tag, "_lock"},   32'(O_LOCK), 0);
        check({tag, "_pc"},     32'(O_PC), 0);
        check({tag, "_opc"},    32'(O_Opcode), 32'h0000_00FF);
        check({tag, "_dest"},   32'(O_DestRegIdx), 0);
        check({tag, "_src1"},   32'(O_Src1Value), 0);
        check({tag, "_src2"},   32'(O_Src2Value), 0);
        check({tag, "_imm"},    32'(O_Imm), 0);
        check({tag, "_valid"},  32'(O_DE_Valid), 0);
        check({tag, "_brstall"},  32'(O_BranchStallSignal), 0);
        check({tag, "_depstall"}, 32'(O_DepStallSignal), 0);
    endtask

    // Monitor: every freshly latched valid instruction must match the oldest expectation
    initial begin : monitor
        exp_t got, want;
        logic gpu_e;
        forever begin
            @(negedge I_CLOCK);
            gpu_e = I_GPUStallSignal;
            #1;
            if (!I_RESET && O_DE_Valid && !gpu_e) begin
                got = {O_PC, O_Opcode, O_DestRegIdx, O_Src1Value, O_Src2Value, O_Imm};
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL monitor_unexpected: got %h, expected no issue", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        n_fail++;
                        $display("FAIL monitor_issue: got %h, expected %h", got, want);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        I_RESET = 1'b1; I_LOCK = 1'b1; I_BranchAddrSelect = 1'b0; I_GPUStallSignal = 1'b0;
        idle(); wb(1'b0, 4'd0, 16'h0000);
        tick(); tick();
        chk_reset_vals("por");
        I_RESET = 1'b0;
        tick();
        check("lock_after_release", 32'(O_LOCK), 1);

        // RAW on R1
        drive(1'b1, ir_rrr(OP_ADD, 4'd1, 4'd0, 4'd0), 16'h0010);
        push(16'h0010, OP_ADD, 4'd1, 16'h0, 16'h0, 16'h0000);
        chk_dep(1'b0, "raw_first_no_stall");
        tick();
        drive(1'b1, ir_rrr(OP_ADD, 4'd2, 4'd1, 4'd1), 16'h0011);
        chk_dep(1'b1, "raw_stall_a");
        tick();
        check("raw_bubble_valid_a", 32'(O_DE_Valid), 0);
        check("raw_bubble_opc_a", 32'(O_Opcode), 32'h0000_00FF);
        chk_dep(1'b1, "raw_stall_b");
        tick();
        check("raw_bubble_valid_b", 32'(O_DE_Valid), 0);
        wb(1'b1, 4'd1, 16'h0005);
        push(16'h0011, OP_ADD, 4'd2, 16'h0005, 16'h0005, 16'h0100);
        chk_dep(1'b0, "raw_release");
        tick();
        wb(1'b0, 4'd0, 16'h0000); idle();

        // Reset while ADD R3 is outstanding, with a writeback to R7 that must be dropped
        drive(1'b1, ir_rrr(OP_ADD, 4'd3, 4'd0, 4'd0), 16'h0020);
        push(16'h0020, OP_ADD, 4'd3, 16'h0, 16'h0, 16'h0000);
        tick();
        idle(); I_RESET = 1'b1; wb(1'b1, 4'd7, 16'hBEEF);
        #1;
        chk_reset_vals("mid_reset");
        tick();
        I_RESET = 1'b0; wb(1'b0, 4'd0, 16'h0000);
        drive(1'b1, ir_rrr(OP_ADD, 4'd8, 4'd7, 4'd3), 16'h0021);
        push(16'h0021, OP_ADD, 4'd8, 16'h0000, 16'h0000, 16'h0300);
        chk_dep(1'b0, "post_reset_r3_free");
        tick();
        check("post_reset_lock", 32'(O_LOCK), 1);
        idle(); wb(1'b1, 4'd8, 16'h1234);
        tick();
        wb(1'b0, 4'd0, 16'h0000);

        // Branch: stall from the next edge until resolve, wrong-path squashed
        drive(1'b1, ir_ri(OP_BRZ, 4'd0, 4'd0, 16'h0040), 16'h0030);
        push(16'h0030, OP_BRZ, 4'd0, 16'h0, 16'h0, 16'h0040);
        check("br_stall_before", 32'(O_BranchStallSignal), 0);
        tick();
        check("br_stall_next_edge", 32'(O_BranchStallSignal), 1);
        drive(1'b1, ir_ri(OP_MOVI, 4'd9, 4'd0, 16'h0077), 16'h0031);
        tick();
        check("br_squash_a", 32'(O_DE_Valid), 0);
        check("br_stall_hold", 32'(O_BranchStallSignal), 1);
        I_BranchAddrSelect = 1'b1;
        tick();
        check("br_squash_b", 32'(O_DE_Valid), 0);
        check("br_stall_cleared", 32'(O_BranchStallSignal), 0);
        I_BranchAddrSelect = 1'b0;
        drive(1'b1, ir_rrr(OP_ADD, 4'd10, 4'd9, 4'd9), 16'h0032);
        push(16'h0032, OP_ADD, 4'd10, 16'h0000, 16'h0000, 16'h0900);
        chk_dep(1'b0, "br_squashed_no_busy");
        tick();
        // Resolve and a new branch on the same edge leaves the flag set
        drive(1'b1, ir_ri(OP_JMP, 4'd0, 4'd0, 16'h0050), 16'h0033);
        I_BranchAddrSelect = 1'b1; wb(1'b1, 4'd10, 16'h00AA);
        push(16'h0033, OP_JMP, 4'd0, 16'h0, 16'h0, 16'h0050);
        tick();
        check("br_set_over_clear", 32'(O_BranchStallSignal), 1);
        I_BranchAddrSelect = 1'b0; wb(1'b0, 4'd0, 16'h0000); idle();
        tick();
        check("br_pending_hold", 32'(O_BranchStallSignal), 1);
        I_BranchAddrSelect = 1'b1;
        tick();
        check("br_resolved", 32'(O_BranchStallSignal), 0);
        I_BranchAddrSelect = 1'b0;

        // Dropping I_LOCK injects bubbles and clears a pending branch
        drive(1'b1, ir_ri(OP_JMP, 4'd0, 4'd0, 16'h0060), 16'h0034);
        push(16'h0034, OP_JMP, 4'd0, 16'h0, 16'h0, 16'h0060);
        tick();
        check("lock_br_set", 32'(O_BranchStallSignal), 1);
        I_LOCK = 1'b0;
        drive(1'b1, ir_rrr(OP_ADD, 4'd11, 4'd0, 4'd0), 16'h0035);
        tick();
        check("lock_bubble_valid", 32'(O_DE_Valid), 0);
        check("lock_out_low", 32'(O_LOCK), 0);
        check("lock_clears_branch", 32'(O_BranchStallSignal), 0);
        I_LOCK = 1'b1; idle();
        tick();
        check("lock_out_high", 32'(O_LOCK), 1);

        // WAW saturation on R4
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ir_rrr(OP_ADD, 4'd4, 4'd0, 4'd0), 16'h0040 + 16'(i));
            push(16'h0040 + 16'(i), OP_ADD, 4'd4, 16'h0, 16'h0, 16'h0000);
            chk_dep(1'b0, "waw_issue");
            tick();
        end
        drive(1'b1, ir_rrr(OP_ADD, 4'd4, 4'd0, 4'd0), 16'h0043);
        chk_dep(1'b1, "waw_saturated");
        tick();
        check("waw_held_valid", 32'(O_DE_Valid), 0);
        wb(1'b1, 4'd4, 16'h0009);
        push(16'h0043, OP_ADD, 4'd4, 16'h0, 16'h0, 16'h0000);
        chk_dep(1'b0, "waw_after_wb");
        tick();
        idle();
        tick(); tick(); tick();
        wb(1'b0, 4'd0, 16'h0000);
        drive(1'b1, ir_rrr(OP_ADD, 4'd12, 4'd4, 4'd0), 16'h0044);
        push(16'h0044, OP_ADD, 4'd12, 16'h0009, 16'h0000, 16'h0000);
        chk_dep(1'b0, "waw_drained");
        tick();
        idle();

        // GPU stall: outputs frozen, writeback still retires R5
        drive(1'b1, ir_rrr(OP_ADD, 4'd5, 4'd0, 4'd0), 16'h0050);
        push(16'h0050, OP_ADD, 4'd5, 16'h0, 16'h0, 16'h0000);
        tick();
        I_GPUStallSignal = 1'b1;
        drive(1'b1, ir_rrr(OP_ADD, 4'd13, 4'd0, 4'd0), 16'h0051);
        wb(1'b1, 4'd5, 16'h0055);
        for (int i = 0; i < 3; i++) begin
            tick();
            wb(1'b0, 4'd0, 16'h0000);
            check("gpu_frozen_pc", 32'(O_PC), 32'h0050);
            check("gpu_frozen_dest", 32'(O_DestRegIdx), 5);
            check("gpu_frozen_valid", 32'(O_DE_Valid), 1);
        end
        I_GPUStallSignal = 1'b0;
        drive(1'b1, ir_rrr(OP_ADD, 4'd14, 4'd5, 4'd5), 16'h0052);
        push(16'h0052, OP_ADD, 4'd14, 16'h0055, 16'h0055, 16'h0500);
        chk_dep(1'b0, "gpu_wb_applied");
        tick();
        idle();

        // Same-edge issue and writeback on R6
        drive(1'b1, ir_rrr(OP_ADD, 4'd6, 4'd0, 4'd0), 16'h0060);
        push(16'h0060, OP_ADD, 4'd6, 16'h0, 16'h0, 16'h0000);
        tick();
        wb(1'b1, 4'd6, 16'h0066);
        drive(1'b1, ir_rrr(OP_ADD, 4'd6, 4'd0, 4'd0), 16'h0061);
        push(16'h0061, OP_ADD, 4'd6, 16'h0, 16'h0, 16'h0000);
        chk_dep(1'b0, "same_edge_no_stall");
        tick();
        wb(1'b0, 4'd0, 16'h0000);
        drive(1'b1, ir_rrr(OP_ADD, 4'd15, 4'd6, 4'd0), 16'h0062);
        chk_dep(1'b1, "same_edge_count_kept");
        tick();
        check("same_edge_bubble", 32'(O_DE_Valid), 0);
        wb(1'b1, 4'd6, 16'h0077);
        push(16'h0062, OP_ADD, 4'd15, 16'h0077, 16'h0000, 16'h0000);
        chk_dep(1'b0, "same_edge_drain");
        tick();
        wb(1'b0, 4'd0, 16'h0000); idle();
        tick(); tick();

        check("expect_queue_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
